// File: rtl/reg_wb_queue.sv
// Four-entry register writeback queue with read-after-write forwarding.
// Optional macro REG_WB_COALESCE_EN merges a same-address write into the newest entry.
module reg_wb_queue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_addr,
    input  logic [15:0] req_data,
    output logic        req_ready,
    input  logic        drain_en,
    output logic        wr,
    output logic [2:0]  wr_addr,
    output logic [15:0] wr_data,
    input  logic [2:0]  rd_addr,
    input  logic [15:0] bank_out,
    output logic [15:0] rd_data,
    output logic        rd_hit,
    output logic [2:0]  count
);

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 16;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] newest;
    logic [PW-1:0] idx;
    logic          accept;
    logic          pop;
    logic          coalesce;
    logic          alloc;

    assign req_ready = (count != CW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign wr        = (count != '0) && drain_en;
    assign pop       = wr;
    assign wr_addr   = mem_addr[head];
    assign wr_data   = mem_data[head];
    assign newest    = tail - PW'(1);

`ifdef REG_WB_COALESCE_EN
    // A lone head entry that is leaving this edge cannot absorb the new write.
    assign coalesce = accept && (count != '0) && (mem_addr[newest] == req_addr)
                      && !(pop && (count == CW'(1)));
`else
    assign coalesce = 1'b0;
`endif
    assign alloc = accept && !coalesce;

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            if (alloc) begin
                tail <= tail + PW'(1);
            end
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

    // Entry storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (alloc) begin
            mem_addr[tail] <= req_addr;
            mem_data[tail] <= req_data;
        end else if (coalesce) begin
            mem_data[newest] <= req_data;
        end
    end

    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        rd_data = bank_out;
        rd_hit  = 1'b0;
        idx     = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (mem_addr[idx] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = mem_data[idx];
            end
        end
    end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 The block SHALL have a single clock and an asynchronous active-low reset: clk, rst_n.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- req_valid  in  1  writeback request from the pipeline.
- req_addr  in  3  destination register.
- req_data  in  16  result value.
- req_ready  out  1  queue can accept a request.
- drain_en  in  1  the bank write port is available this cycle.
- wr  out  1  bank write strobe.
- wr_addr  out  3  bank write address.
- wr_data  out  16  bank write data, driven to the bank's in port.
- rd_addr  in  3  decode-stage read address, also sent to the bank.
- bank_out  in  16  bank combinational read data.
- rd_data  out  16  forwarded read data.
- rd_hit  out  1  rd_data was taken from the queue.
- count  out  3  number of occupied entries, 0..4.

Function
REQ-003 The block SHALL be a 4-entry FIFO of {addr[2:0], data[15:0]} with 2-bit head and tail pointers that wrap from 3 to 0.
REQ-004 req_ready SHALL equal (count != 4), combinationally; it SHALL NOT depend on drain_en.
REQ-005 A request SHALL be accepted at a rising clk edge when req_valid && req_ready; it is written at tail and tail increments.
REQ-006 If req_valid is high while req_ready is low, the request SHALL be ignored; the source holds it.
REQ-007 Outputs SHALL be combinational from the head entry: wr = (count != 0) && drain_en; wr_addr = head.addr; wr_data = head.data.
REQ-008 When wr is high, the head SHALL pop at the same rising edge at which the bank captures the write.
REQ-009 Latency into an empty queue with drain_en=1: a request accepted at edge N drives wr during cycle N..N+1 and is written into the bank at edge N+1.
REQ-010 Accept and pop in the same edge SHALL leave count unchanged.
REQ-011 An accept into a full queue SHALL NOT occur, even if a pop happens in the same cycle.
REQ-012 When count=0, wr SHALL be 0 and wr_addr/wr_data are don't-care.
REQ-013 Forwarding: rd_data SHALL be the data of the newest occupied entry whose addr equals rd_addr, and rd_hit=1; if no entry matches, rd_data = bank_out and rd_hit=0.
REQ-014 Forwarding SHALL include the head entry even when it is being popped this cycle.
REQ-015 Forwarding SHALL NOT include a request being accepted in the same cycle.
REQ-016 count SHALL be registered and always equal to the number of occupied entries.

Reset
REQ-017 While rst_n=0, regardless of clk: head=0, tail=0, count=0.
REQ-018 While rst_n=0: wr=0, rd_hit=0, and rd_data = bank_out.
REQ-019 Entry storage SHALL NOT need a reset value.
REQ-020 Reset asserted mid-operation SHALL discard all pending entries without issuing a bank write.
REQ-021 The first request after reset release SHALL be accepted at the first clk edge at which rst_n=1.

Configuration
REQ-022 The macro REG_WB_COALESCE_EN SHALL control write coalescing into the newest entry.
- When defined: an accepted request whose req_addr equals the newest entry's addr SHALL overwrite that entry's data, with no allocation and no change to count. This SHALL apply unless that entry is the head and is popping this edge, in which case a new entry is allocated.
- When undefined: every accepted request SHALL allocate a new entry.
- In both cases req_ready SHALL follow REQ-004.

Verification
REQ-023 Reset, then one request (addr=3, data=16'h00A5) with drain_en=1 -> wr=1, wr_addr=3, wr_data=16'h00A5 for exactly one cycle; count goes 1 then 0.
REQ-024 drain_en=0, issue 5 requests with addr 1..5 -> count=4 and req_ready=0 after the 4th; the 5th is held. drain_en=1 -> bank writes occur in order 1,2,3,4, then 5.
REQ-025 Queue holds addr2=10 then addr2=20, bank_out=7, rd_addr=2 -> rd_data=20, rd_hit=1. With rd_addr=6 -> rd_data=7, rd_hit=0.
REQ-026 Full queue with drain_en=1 and req_valid=1 for one edge -> exactly one pop, no accept, count=3 after that edge.
REQ-027 3 entries pending, pulse rst_n low between edges -> count=0 and wr=0 immediately; no further bank writes.
REQ-028 With REG_WB_COALESCE_EN and drain_en=0, requests addr4=1 then addr4=9 -> count=1 and the drained bank write is addr 4, data 9. Without the macro -> count=2 and writes 1 then 9.
